time_set_ctrl: RTL

Button-driven controller that lets the user edit the running date/time and write it back into the time-of-day counter. It snapshots the counter's current year/month/day/hour/minute/second/week, steps through the fields with up/down adjustment, and issues a single-cycle load strobe carrying the edited values. It sits between the debounced front-panel buttons and the time counter's load port. Its `field` output also drives field blinking on the display.

---
 rtl/time_set_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/time_set_ctrl.sv
// Front-panel time/date editor: snapshots the live counter, steps through the fields with
// up/down wrap-around adjustment and emits a one-cycle load strobe carrying the edited values.
module time_set_ctrl #(
   parameter int unsigned YEAR_MIN       = 2000,
   parameter int unsigned YEAR_MAX       = 2099,
   parameter int unsigned TIMEOUT_CYCLES = 30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_mode,
   input  logic        btn_next,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic [15:0] cur_year,
   input  logic [5:0]  cur_month,
   input  logic [10:0] cur_day,
   input  logic [10:0] cur_hour,
   input  logic [10:0] cur_minute,
   input  logic [10:0] cur_second,
   input  logic [10:0] cur_week,
   output logic [15:0] set_year,
   output logic [5:0]  set_month,
   output logic [10:0] set_day,
   output logic [10:0] set_hour,
   output logic [10:0] set_minute,
   output logic [10:0] set_second,
   output logic [10:0] set_week,
   output logic        load,
   output logic        editing,
   output logic [2:0]  field
);

   localparam int unsigned TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [15:0] YMin = 16'(YEAR_MIN);
   localparam logic [15:0] YMax = 16'(YEAR_MAX);

   typedef enum logic [3:0] {
      StIdle, StYear, StMonth, StDay, StHour, StMinute, StSecond, StWeek, StCommit
   } state_e;

   function automatic logic is_leap(input logic [15:0] y);
      return (((y % 16'd4) == 16'd0) && ((y % 16'd100) != 16'd0)) || ((y % 16'd400) == 16'd0);
   endfunction

   function automatic logic [10:0] max_day(input logic [5:0] m, input logic [15:0] y);
      case (m)
         6'd4, 6'd6, 6'd9, 6'd11: return 11'd30;
         6'd2:                    return is_leap(y) ? 11'd29 : 11'd28;
         default:                 return 11'd31;
      endcase
   endfunction

   // Out-of-range values snap to the minimum on the first adjustment.
   function automatic logic [15:0] step(input logic [15:0] v, input logic [15:0] mn,
                                        input logic [15:0] mx, input logic up);
      if (v < mn || v > mx) return mn;
      if (up) return (v == mx) ? mn : v + 16'd1;
      return (v == mn) ? mx : v - 16'd1;
   endfunction

   state_e        state_q, state_d;
   logic [15:0]   year_q, year_d;
   logic [5:0]    month_q, month_d;
   logic [10:0]   day_q, day_d, hour_q, hour_d, minute_q, minute_d;
   logic [10:0]   second_q, second_d, week_q, week_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          load_q, load_d, editing_q, editing_d;
   logic [2:0]    field_q, field_d;

   logic          any_btn, adj, is_edit;
   logic [15:0]   tmp;
   logic [10:0]   md_new;

   assign any_btn = btn_mode | btn_next | btn_up | btn_down;
   assign adj     = !btn_mode && !btn_next && (btn_up || btn_down);
   assign is_edit = (state_q != StIdle) && (state_q != StCommit);

   always_comb begin
      state_d  = state_q;
      year_d   = year_q;
      month_d  = month_q;
      day_d    = day_q;
      hour_d   = hour_q;
      minute_d = minute_q;
      second_d = second_q;
      week_d   = week_q;
      timer_d  = '0;
      tmp      = '0;
      md_new   = max_day(month_q, year_q);

      case (state_q)
         StIdle: begin
            if (btn_mode) begin
               year_d   = cur_year;
               month_d  = cur_month;
               day_d    = cur_day;
               hour_d   = cur_hour;
               minute_d = cur_minute;
               second_d = cur_second;
               week_d   = cur_week;
               state_d  = StYear;
            end
         end
         StCommit: state_d = StIdle;
         default: begin
            if (btn_mode) begin
               state_d = StIdle;
            end else if (btn_next) begin
               case (state_q)
                  StYear:   state_d = StMonth;
                  StMonth:  state_d = StDay;
                  StDay:    state_d = StHour;
                  StHour:   state_d = StMinute;
                  StMinute: state_d = StSecond;
                  StSecond: state_d = StWeek;
                  default:  state_d = StCommit;
               endcase
            end else if (adj) begin
               // btn_up outranks btn_down, so btn_up alone selects the direction.
               case (state_q)
                  StYear: begin
                     year_d = step(year_q, YMin, YMax, btn_up);
                     md_new = max_day(month_q, year_d);
                     if (day_q > md_new) day_d = md_new;
                  end
                  StMonth: begin
                     tmp     = step({10'd0, month_q}, 16'd1, 16'd12, btn_up);
                     month_d = tmp[5:0];
                     md_new  = max_day(month_d, year_q);
                     if (day_q > md_new) day_d = md_new;
                  end
                  StDay: begin
                     tmp   = step({5'd0, day_q}, 16'd1, {5'd0, md_new}, btn_up);
                     day_d = tmp[10:0];
                  end
                  StHour: begin
                     tmp    = step({5'd0, hour_q}, 16'd0, 16'd23, btn_up);
                     hour_d = tmp[10:0];
                  end
                  StMinute: begin
                     tmp      = step({5'd0, minute_q}, 16'd0, 16'd59, btn_up);
                     minute_d = tmp[10:0];
                  end
                  StSecond: begin
                     tmp      = step({5'd0, second_q}, 16'd0, 16'd59, btn_up);
                     second_d = tmp[10:0];
                  end
                  default: begin
                     tmp    = step({5'd0, week_q}, 16'd1, 16'd7, btn_up);
                     week_d = tmp[10:0];
                  end
               endcase
            end
         end
      endcase

      if (is_edit && !any_btn && TIMEOUT_CYCLES != 0) begin
         if (32'(timer_q) + 32'd1 >= TIMEOUT_CYCLES) begin
            state_d = StIdle;
         end else begin
            timer_d = timer_q + TW'(1);
         end
      end

      load_d    = (state_d == StCommit);
      editing_d = (state_d != StIdle);
      case (state_d)
         StYear:   field_d = 3'd1;
         StMonth:  field_d = 3'd2;
         StDay:    field_d = 3'd3;
         StHour:   field_d = 3'd4;
         StMinute: field_d = 3'd5;
         StSecond: field_d = 3'd6;
         StWeek:   field_d = 3'd7;
         default:  field_d = 3'd0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         year_q    <= YMin;
         month_q   <= 6'd1;
         day_q     <= 11'd1;
         hour_q    <= '0;
         minute_q  <= '0;
         second_q  <= '0;
         week_q    <= 11'd1;
         timer_q   <= '0;
         load_q    <= 1'b0;
         editing_q <= 1'b0;
         field_q   <= '0;
      end else begin
         state_q   <= state_d;
         year_q    <= year_d;
         month_q   <= month_d;
         day_q     <= day_d;
         hour_q    <= hour_d;
         minute_q  <= minute_d;
         second_q  <= second_d;
         week_q    <= week_d;
         timer_q   <= timer_d;
         load_q    <= load_d;
         editing_q <= editing_d;
         field_q   <= field_d;
      end
   end

   assign set_year   = year_q;
   assign set_month  = month_q;
   assign set_day    = day_q;
   assign set_hour   = hour_q;
   assign set_minute = minute_q;
   assign set_second = second_q;
   assign set_week   = week_q;
   assign load       = load_q;
   assign editing    = editing_q;
   assign field      = field_q;

endmodule
